// File: rtl/dm_port_arbiter.sv
// Two-master arbiter for the single data-memory port (CPU M-stage vs. DMA/loader).
// Default is CPU priority with a DMA starvation limit; define DM_ARB_RR_EN for round-robin.
module dm_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_byteen,
  output logic                cpu_stall,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_rvalid,
  input  logic                dma_req,
  input  logic                dma_we,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]   dma_wdata,
  input  logic [DATA_W/8-1:0] dma_byteen,
  output logic                dma_gnt,
  output logic [DATA_W-1:0]   dma_rdata,
  output logic                dma_rvalid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byteen,
  output logic                mem_re,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  logic                grantCpu, grantDma, accept;
  logic                selWe;
  logic [ADDR_W-1:0]   selAddr;
  logic [DATA_W-1:0]   selWdata;
  logic [BE_W-1:0]     selByteen;

  logic [ADDR_W-1:0]   memAddr_q;
  logic [DATA_W-1:0]   memWdata_q;
  logic [BE_W-1:0]     memByteen_q;
  logic                memRe_q;
  logic [DATA_W-1:0]   cpuRdata_q, dmaRdata_q;
  logic                cpuRvalid_q, dmaRvalid_q;
  logic [RD_LAT:0]     tagValid_q, tagDma_q;

`ifdef DM_ARB_RR_EN
  logic rrPtr_q, rrPtr_d;

  // A set pointer means DMA takes the next contested cycle.
  always_comb begin
    grantDma = dma_req;
    rrPtr_d  = rrPtr_q;
    if (cpu_req && dma_req) begin
      grantDma = rrPtr_q;
      rrPtr_d  = ~rrPtr_q;
    end
    grantCpu = cpu_req && !grantDma;
  end

  always_ff @(posedge clk) begin
    if (!reset) rrPtr_q <= 1'b0;
    else        rrPtr_q <= rrPtr_d;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starveCnt_q, starveCnt_d;

  always_comb begin
    grantDma = dma_req;
    if (cpu_req && dma_req) grantDma = (starveCnt_q == STARVE_LIM);
    grantCpu    = cpu_req && !grantDma;
    starveCnt_d = '0;
    if (dma_req && !grantDma)
      starveCnt_d = (starveCnt_q == STARVE_LIM) ? starveCnt_q : starveCnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) starveCnt_q <= '0;
    else        starveCnt_q <= starveCnt_d;
  end
`endif

  assign accept    = grantCpu || grantDma;
  assign cpu_stall = cpu_req && !grantCpu;
  assign dma_gnt   = grantDma;

  always_comb begin
    selWe     = cpu_we;
    selAddr   = cpu_addr;
    selWdata  = cpu_wdata;
    selByteen = cpu_byteen;
    if (grantDma) begin
      selWe     = dma_we;
      selAddr   = dma_addr;
      selWdata  = dma_wdata;
      selByteen = dma_byteen;
    end
  end

  // Issue stage plus owner-tag pipe; the tag at index RD_LAT lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (!reset) begin
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      memByteen_q <= '0;
      memRe_q     <= 1'b0;
      cpuRdata_q  <= '0;
      cpuRvalid_q <= 1'b0;
      dmaRdata_q  <= '0;
      dmaRvalid_q <= 1'b0;
      tagValid_q  <= '0;
      tagDma_q    <= '0;
    end else begin
      if (accept) begin
        memAddr_q  <= selAddr & ~ADDR_W'(3);
        memWdata_q <= selWdata;
      end
      memByteen_q <= (accept && selWe) ? selByteen : '0;
      memRe_q     <= accept && !selWe;
      for (int i = RD_LAT; i > 0; i--) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagDma_q[i]   <= tagDma_q[i-1];
      end
      tagValid_q[0] <= accept && !selWe;
      tagDma_q[0]   <= grantDma;
      cpuRvalid_q   <= tagValid_q[RD_LAT] && !tagDma_q[RD_LAT];
      dmaRvalid_q   <= tagValid_q[RD_LAT] && tagDma_q[RD_LAT];
      if (tagValid_q[RD_LAT] && !tagDma_q[RD_LAT]) cpuRdata_q <= mem_rdata;
      if (tagValid_q[RD_LAT] && tagDma_q[RD_LAT])  dmaRdata_q <= mem_rdata;
    end
  end

  assign mem_addr   = memAddr_q;
  assign mem_wdata  = memWdata_q;
  assign mem_byteen = memByteen_q;
  assign mem_re     = memRe_q;
  assign cpu_rdata  = cpuRdata_q;
  assign cpu_rvalid = cpuRvalid_q;
  assign dma_rdata  = dmaRdata_q;
  assign dma_rvalid = dmaRvalid_q;

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port (word address, write data, 4-bit byte enable, read data) between two requesters: the pipeline M-stage (CPU) and a DMA/loader engine.
- Arbitrates each cycle and registers the winner onto the memory port.
- Routes read data back to the correct owner after a fixed memory latency.
- Stalls the CPU while the port is held by DMA.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enable width is DATA_W/8.
- RD_LAT, 0, memory read latency in cycles after mem_re is presented; legal 0..3 (0 = combinational read).
- STARVE_MAX, 4, consecutive denied DMA cycles before DMA is forced a grant; legal 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  byte address
- cpu_wdata  in  DATA_W  write data
- cpu_byteen  in  DATA_W/8  write byte enables
- cpu_stall  out  1  request not accepted this cycle
- cpu_rdata  out  DATA_W  read data
- cpu_rvalid  out  1  cpu_rdata valid (1-cycle pulse)
- dma_req, dma_we, dma_addr, dma_wdata, dma_byteen  in  as CPU  DMA request fields
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rdata  out  DATA_W  read data
- dma_rvalid  out  1  dma_rdata valid
- mem_addr  out  ADDR_W  word-aligned address (addr & ~3)
- mem_wdata  out  DATA_W  write data
- mem_byteen  out  DATA_W/8  byte enables; all zero for reads
- mem_re  out  1  read strobe
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset: clk edge with reset=0 clears to 0 every registered output (mem_addr, mem_wdata, mem_byteen, mem_re, cpu_rdata, cpu_rvalid, dma_rdata, dma_rvalid), the starvation counter, the RR pointer and the return-tag pipe.
- In-flight reads at reset are discarded; no rvalid is produced for them after reset releases.
- Handshake: a requester holds req and all fields stable until accepted.
  - CPU accepted when cpu_req && !cpu_stall.
  - DMA accepted when dma_gnt.
  - cpu_stall and dma_gnt are combinational from the inputs and current state. cpu_stall = cpu_req && !grant_cpu.
- Arbitration, CPU priority, per cycle:
  - Only one requester: it wins.
  - Both requesting: CPU wins unless starve_cnt == STARVE_MAX, in which case DMA wins.
  - starve_cnt increments (saturating at STARVE_MAX) in each cycle dma_req=1 and DMA is not granted. It clears on a DMA grant or when dma_req=0.
- Issue: at the edge ending acceptance cycle N, the winner's fields are registered onto the memory port, valid during cycle N+1.
  - Write (we=1): mem_byteen = byteen, mem_re = 0. A write with byteen = 0 is accepted as a no-op.
  - Read (we=0): mem_byteen = 0, mem_re = 1.
  - With no acceptance, the next cycle has mem_byteen = 0 and mem_re = 0. mem_addr and mem_wdata hold their last value.
- Return path:
  - An owner tag (valid, is_dma) enters a shift pipe of depth RD_LAT+1 when a read issues.
  - Reads accepted in cycle N see rdata sampled from mem_rdata in cycle N+1+RD_LAT. The corresponding *_rdata/*_rvalid is registered and visible in cycle N+2+RD_LAT.
  - rvalid is high for exactly one cycle. rdata holds its value until the next return to that owner.
- Back-to-back: one access per cycle is sustained; reads and writes may interleave freely. Memory ordering is issue order.
- Full-throughput boundary: CPU requesting every cycle with DMA waiting gives DMA exactly one grant per STARVE_MAX+1 cycles.
- Write data is not checked against in-flight reads; the memory resolves ordering.

Optional Feature:
- Macro DM_ARB_RR_EN.
- Defined:
  - When both request, the winner alternates via a 1-bit pointer, flipped after every contested grant.
  - The pointer resets to CPU-first.
  - The starvation counter is omitted. STARVE_MAX is ignored.
- Undefined: CPU-priority arbitration with starvation counter as above.

Test Plan:
- Reset mid-read: RD_LAT=2, CPU read of 0x10 accepted, reset asserted the next cycle for 1 cycle -> all outputs 0, no cpu_rvalid ever appears for that read.
- CPU write: cpu_addr=0x0000_0007, byteen=4'b0011, wdata=0xDEADBEEF, DMA idle -> next cycle mem_addr=0x4, mem_byteen=0011, mem_wdata=0xDEADBEEF, cpu_stall=0.
- CPU read: RD_LAT=0, memory word 0x8 = 0x12345678 -> cpu_rvalid pulses 2 cycles after acceptance with cpu_rdata=0x12345678, dma_rvalid stays 0.
- Starvation: STARVE_MAX=4, cpu_req and dma_req held high for 20 cycles -> dma_gnt high on cycles 5, 10, 15, 20; cpu_stall high exactly on those cycles.
- Interleaved reads: RD_LAT=1, CPU reads 0x0 (=0xA), then DMA reads 0x4 (=0xB) in consecutive cycles -> cpu_rvalid with 0xA, then dma_rvalid with 0xB one cycle later; no cross-routing.
- DM_ARB_RR_EN: both requesting continuously for 6 cycles -> grants alternate CPU, DMA, CPU, DMA, CPU, DMA.
